// File: rtl/cache_refill_ctrl_pkg.sv
// Shared definitions for the cache refill controller.
// Holds the default geometry and the controller FSM state encoding.
package cache_refill_ctrl_pkg;
  localparam int DEF_INDEX_LENGTH   = 5;
  localparam int DEF_CACHE_LINES    = 32;
  localparam int DEF_TAG_LENGTH     = 8;
  localparam int DEF_WORDS_PER_LINE = 4;
  localparam int DEF_DATA_WIDTH     = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOOKUP = 2'd1,
    ST_FILL   = 2'd2,
    ST_COMMIT = 2'd3
  } refill_state_e;
endpackage

// File: rtl/cache_refill_ctrl_tag_store.sv
// cache_tag_store: per-line valid bit and tag.
// Ports:
//   clk, rstn            clock, synchronous active-low reset (clears all valid bits)
//   rd_index -> rd_valid, rd_tag   combinational read
//   wr_en, wr_index, wr_valid, wr_tag  synchronous write (tag only stored when wr_valid)
//   clr_en, clr_index    synchronous clear of one valid bit; wins over a same-cycle write
module cache_tag_store
  import cache_refill_ctrl_pkg::*;
#(
  parameter int INDEX_LENGTH = DEF_INDEX_LENGTH,
  parameter int CACHE_LINES  = DEF_CACHE_LINES,
  parameter int TAG_LENGTH   = DEF_TAG_LENGTH
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [INDEX_LENGTH-1:0] rd_index,
  output logic                    rd_valid,
  output logic [TAG_LENGTH-1:0]   rd_tag,
  input  logic                    wr_en,
  input  logic [INDEX_LENGTH-1:0] wr_index,
  input  logic                    wr_valid,
  input  logic [TAG_LENGTH-1:0]   wr_tag,
  input  logic                    clr_en,
  input  logic [INDEX_LENGTH-1:0] clr_index
);
  logic [CACHE_LINES-1:0]                 valid_q;
  logic [CACHE_LINES-1:0][TAG_LENGTH-1:0] tag_q;

  assign rd_valid = valid_q[rd_index];
  assign rd_tag   = tag_q[rd_index];

  // The clear is written last so an invalidate always beats a commit.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      valid_q <= '0;
    end else begin
      if (wr_en)  valid_q[wr_index]  <= wr_valid;
      if (clr_en) valid_q[clr_index] <= 1'b0;
    end
  end

  // Tags need no reset: they are never looked at while the valid bit is low.
  always_ff @(posedge clk) begin
    if (wr_en && wr_valid) tag_q[wr_index] <= wr_tag;
  end
endmodule

// File: rtl/cache_refill_ctrl.sv
// cache_refill_ctrl: lookup / miss-refill controller for a direct-mapped cache.
// Ports:
//   clk_i, rstn_i                    clock, synchronous active-low reset
//   req_valid_i/req_ready_o, req_index_i, req_tag_i   lookup request handshake
//   hit_o, fill_done_o               one-cycle result pulses
//   inv_i, inv_index_i               line invalidate, any cycle
//   mem_req_o, mem_addr_o, mem_ack_i, mem_data_i      word refill from memory
//   line_we_o, line_index_o, line_word_o, line_data_o data-array write port
//   busy_o                           high whenever not IDLE
module cache_refill_ctrl
  import cache_refill_ctrl_pkg::*;
#(
  parameter int INDEX_LENGTH   = DEF_INDEX_LENGTH,
  parameter int CACHE_LINES    = DEF_CACHE_LINES,
  parameter int TAG_LENGTH     = DEF_TAG_LENGTH,
  parameter int WORDS_PER_LINE = DEF_WORDS_PER_LINE,
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  localparam int OFF_W         = $clog2(WORDS_PER_LINE),
  localparam int ADDR_W        = TAG_LENGTH + INDEX_LENGTH + OFF_W
) (
  input  logic                    clk_i,
  input  logic                    rstn_i,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic [INDEX_LENGTH-1:0] req_index_i,
  input  logic [TAG_LENGTH-1:0]   req_tag_i,
  output logic                    hit_o,
  output logic                    fill_done_o,
  input  logic                    inv_i,
  input  logic [INDEX_LENGTH-1:0] inv_index_i,
  output logic                    mem_req_o,
  output logic [ADDR_W-1:0]       mem_addr_o,
  input  logic                    mem_ack_i,
  input  logic [DATA_WIDTH-1:0]   mem_data_i,
  output logic                    line_we_o,
  output logic [INDEX_LENGTH-1:0] line_index_o,
  output logic [OFF_W-1:0]        line_word_o,
  output logic [DATA_WIDTH-1:0]   line_data_o,
  output logic                    busy_o
);
  refill_state_e             state_q, state_d;
  logic [INDEX_LENGTH-1:0]   idx_q;
  logic [TAG_LENGTH-1:0]     tag_q;
  logic [OFF_W-1:0]          cnt_q;
  logic                      kill_q;

  logic                      rd_valid;
  logic [TAG_LENGTH-1:0]     rd_tag;
  logic                      st_wr_en, st_wr_valid;
  logic                      lookup_hit, inv_match;

  assign lookup_hit = rd_valid && (rd_tag == tag_q);
  assign inv_match  = inv_i && (inv_index_i == idx_q);

  cache_tag_store #(
    .INDEX_LENGTH (INDEX_LENGTH),
    .CACHE_LINES  (CACHE_LINES),
    .TAG_LENGTH   (TAG_LENGTH)
  ) u_tag_store (
    .clk       (clk_i),
    .rstn      (rstn_i),
    .rd_index  (idx_q),
    .rd_valid  (rd_valid),
    .rd_tag    (rd_tag),
    .wr_en     (st_wr_en),
    .wr_index  (idx_q),
    .wr_valid  (st_wr_valid),
    .wr_tag    (tag_q),
    .clr_en    (inv_i),
    .clr_index (inv_index_i)
  );

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      tag_q   <= '0;
      cnt_q   <= '0;
      kill_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        ST_IDLE: if (req_valid_i) begin
          idx_q <= req_index_i;
          tag_q <= req_tag_i;
        end
        ST_LOOKUP: if (!lookup_hit) begin
          cnt_q  <= '0;
          kill_q <= 1'b0;
        end
        ST_FILL: begin
          // Counter wraps to 0 on the last word, ready for the next fill.
          if (mem_ack_i) cnt_q <= cnt_q + 1'b1;
          if (inv_match) kill_q <= 1'b1;
        end
        default: kill_q <= 1'b0;
      endcase
    end
  end

  always_comb begin
    state_d     = state_q;
    hit_o       = 1'b0;
    fill_done_o = 1'b0;
    mem_req_o   = 1'b0;
    line_we_o   = 1'b0;
    st_wr_en    = 1'b0;
    st_wr_valid = 1'b0;
    case (state_q)
      ST_IDLE: if (req_valid_i) state_d = ST_LOOKUP;
      ST_LOOKUP: begin
        if (lookup_hit) begin
          hit_o   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          // Drop the old line now so nothing can hit a half-filled line.
          st_wr_en = 1'b1;
          state_d  = ST_FILL;
        end
      end
      ST_FILL: begin
        mem_req_o = 1'b1;
        if (mem_ack_i) begin
          line_we_o = 1'b1;
          if (&cnt_q) state_d = ST_COMMIT;
        end
      end
      ST_COMMIT: begin
        fill_done_o = 1'b1;
        st_wr_en    = 1'b1;
        // An invalidate landing in this very cycle also kills the fill.
        st_wr_valid = !(kill_q || inv_match);
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign req_ready_o  = (state_q == ST_IDLE);
  assign busy_o       = (state_q != ST_IDLE);
  assign mem_addr_o   = {tag_q, idx_q, cnt_q};
  assign line_index_o = idx_q;
  assign line_word_o  = cnt_q;
  assign line_data_o  = mem_data_i;
endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Directed bench for cache_refill_ctrl. A transaction-level model (valid/tag
// arrays plus per-cycle expected outputs derived from hit/miss and word order)
// is compared against the DUT on every negative clock edge.
module tb_cache_refill_ctrl;
  localparam int IW = 5, TW = 8, WPL = 4, OW = 2, DW = 32, AW = 15;

  logic          clk = 1'b0;
  logic          rstn_i = 1'b0;
  logic          req_valid_i = 1'b0;
  logic          req_ready_o;
  logic [IW-1:0] req_index_i = '0;
  logic [TW-1:0] req_tag_i = '0;
  logic          hit_o, fill_done_o;
  logic          inv_i = 1'b0;
  logic [IW-1:0] inv_index_i = '0;
  logic          mem_req_o;
  logic [AW-1:0] mem_addr_o;
  logic          mem_ack_i = 1'b0;
  logic [DW-1:0] mem_data_i = '0;
  logic          line_we_o;
  logic [IW-1:0] line_index_o;
  logic [OW-1:0] line_word_o;
  logic [DW-1:0] line_data_o;
  logic          busy_o;

  always #5 clk = ~clk;

  cache_refill_ctrl dut (
    .clk_i(clk), .rstn_i(rstn_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_index_i(req_index_i), .req_tag_i(req_tag_i),
    .hit_o(hit_o), .fill_done_o(fill_done_o),
    .inv_i(inv_i), .inv_index_i(inv_index_i),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o),
    .mem_ack_i(mem_ack_i), .mem_data_i(mem_data_i),
    .line_we_o(line_we_o), .line_index_o(line_index_o),
    .line_word_o(line_word_o), .line_data_o(line_data_o),
    .busy_o(busy_o)
  );

  // Model state and per-cycle expectations
  bit            mvalid [32];
  logic [TW-1:0] mtag   [32];
  bit            chk_en = 0;
  bit            e_ready, e_busy, e_hit, e_done, e_mreq, e_we;
  logic [AW-1:0] e_addr;
  logic [IW-1:0] e_idx;
  logic [OW-1:0] e_word;
  logic [DW-1:0] e_data;
  int            n_chk = 0, n_fail = 0;
  int            hit_cnt = 0, done_cnt = 0, we_cnt = 0, mreq_cyc = 0;
  logic [AW-1:0] first_addr = '0;
  bit            first_seen = 0;

  function automatic logic [DW-1:0] wdata(input logic [AW-1:0] a);
    return 32'hC0DE_0000 | {17'b0, a};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) if (chk_en) begin
    chk("req_ready", 32'(req_ready_o), 32'(e_ready));
    chk("busy",      32'(busy_o),      32'(e_busy));
    chk("hit",       32'(hit_o),       32'(e_hit));
    chk("fill_done", 32'(fill_done_o), 32'(e_done));
    chk("mem_req",   32'(mem_req_o),   32'(e_mreq));
    chk("line_we",   32'(line_we_o),   32'(e_we));
    if (e_mreq) chk("mem_addr", 32'(mem_addr_o), 32'(e_addr));
    if (e_we) begin
      chk("line_index", 32'(line_index_o), 32'(e_idx));
      chk("line_word",  32'(line_word_o),  32'(e_word));
      chk("line_data",  line_data_o,       e_data);
    end
    if (mem_req_o && !first_seen) begin first_addr = mem_addr_o; first_seen = 1; end
    if (hit_o)       hit_cnt++;
    if (fill_done_o) done_cnt++;
    if (line_we_o)   we_cnt++;
    if (mem_req_o)   mreq_cyc++;
  end

  task automatic step();
    @(posedge clk); #1;
    req_valid_i = 1'b0; mem_ack_i = 1'b0; inv_i = 1'b0;
  endtask

  task automatic exp_idle();
    e_ready = 1; e_busy = 0; e_hit = 0; e_done = 0; e_mreq = 0; e_we = 0;
  endtask

  task automatic exp_busy();
    e_ready = 0; e_busy = 1; e_hit = 0; e_done = 0; e_mreq = 0; e_we = 0;
  endtask

  // One request. inv_word: word of the fill whose first cycle carries an
  // invalidate of inv_idx (-2 = during the lookup cycle, -1 = none).
  // rst_word: word whose first cycle has reset asserted (-1 = none).
  task automatic do_req(input logic [IW-1:0] idx, input logic [TW-1:0] tg, input int stall,
                        input int inv_word, input logic [IW-1:0] inv_idx, input int rst_word);
    bit hit, killed, aborted;
    hit = mvalid[idx] && (mtag[idx] == tg);
    killed = 0; aborted = 0;
    step(); exp_idle();
    req_valid_i = 1'b1; req_index_i = idx; req_tag_i = tg;
    step(); exp_busy(); e_hit = hit;
    if (inv_word == -2) begin inv_i = 1'b1; inv_index_i = inv_idx; end
    if (!hit) mvalid[idx] = 0;
    if (inv_word == -2) mvalid[inv_idx] = 0;
    if (!hit) begin
      for (int w = 0; w < WPL && !aborted; w++) begin
        for (int s = 0; s <= stall && !aborted; s++) begin
          step(); exp_busy();
          e_mreq = 1; e_addr = {tg, idx, OW'(w)};
          e_idx = idx; e_word = OW'(w); e_data = wdata(e_addr);
          e_we = (s == stall);
          mem_ack_i = e_we; mem_data_i = wdata(e_addr);
          if (w == inv_word && s == 0) begin
            inv_i = 1'b1; inv_index_i = inv_idx; mvalid[inv_idx] = 0;
            if (inv_idx == idx) killed = 1;
          end
          if (w == rst_word && s == 0) begin
            rstn_i = 1'b0; mem_ack_i = 1'b0; e_we = 0;
            aborted = 1;
          end
        end
      end
      if (aborted) begin
        // Back in IDLE; a late ack must not write anything.
        step(); exp_idle();
        rstn_i = 1'b1; mem_ack_i = 1'b1; mem_data_i = 32'hDEAD_BEEF;
        foreach (mvalid[i]) mvalid[i] = 0;
      end else begin
        step(); exp_busy(); e_done = 1;
        mvalid[idx] = !killed; mtag[idx] = tg;
      end
    end
    step(); exp_idle();
  endtask

  initial begin
    foreach (mtag[i]) mtag[i] = '0;
    rstn_i = 1'b0;
    @(posedge clk); @(posedge clk);
    step(); rstn_i = 1'b1; exp_idle(); chk_en = 1;

    // Cold miss, then hit on the same line
    do_req(5'd3, 8'h12, 0, -1, 5'd0, -1);
    chk("first_addr", 32'(first_addr), 32'h090C);
    chk("we_cnt_s1", 32'(we_cnt), 32'd4);
    chk("done_cnt_s1", 32'(done_cnt), 32'd1);
    do_req(5'd3, 8'h12, 0, -1, 5'd0, -1);
    chk("hit_cnt_s2", 32'(hit_cnt), 32'd1);
    chk("mreq_cyc_s2", 32'(mreq_cyc), 32'd4);

    // Tag conflict evicts the line
    do_req(5'd3, 8'h34, 0, -1, 5'd0, -1);
    do_req(5'd3, 8'h12, 0, -1, 5'd0, -1);
    chk("done_cnt_s3", 32'(done_cnt), 32'd3);

    // Slow memory: 5 stall cycles per word
    do_req(5'd9, 8'hAB, 5, -1, 5'd0, -1);
    chk("mreq_cyc_s4", 32'(mreq_cyc), 32'd36);
    chk("we_cnt_s4", 32'(we_cnt), 32'd16);

    // Invalidate the filling line at word 2: fill completes but line stays invalid
    do_req(5'd7, 8'h55, 1, 2, 5'd7, -1);
    do_req(5'd7, 8'h55, 0, -1, 5'd0, -1);
    chk("done_cnt_s5", 32'(done_cnt), 32'd6);

    // Invalidate in the lookup cycle: hit seen, line gone afterwards
    do_req(5'd9, 8'hAB, 0, -2, 5'd9, -1);
    do_req(5'd9, 8'hAB, 0, -1, 5'd0, -1);
    chk("hit_cnt_s6", 32'(hit_cnt), 32'd2);
    chk("done_cnt_s6", 32'(done_cnt), 32'd7);

    // Reset during word 1 of a fill; previously valid line must miss
    do_req(5'd12, 8'h01, 2, -1, 5'd0, 1);
    do_req(5'd3, 8'h12, 0, -1, 5'd0, -1);
    chk("hit_cnt_s7", 32'(hit_cnt), 32'd2);
    chk("done_cnt_s7", 32'(done_cnt), 32'd8);
    chk("we_cnt_s7", 32'(we_cnt), 32'd33);
    chk("mreq_cyc_s7", 32'(mreq_cyc), 32'd60);

    chk_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
